// File: rtl/ysyx_22050710_lsu.sv
// Load/store unit: one outstanding access, lane alignment of store data and extension of load data.
// Latency: 3 cycles minimum (accept, req, wait, resp); fast-path errors and no-ops respond in 1 cycle; accepts only in IDLE.
module ysyx_22050710_lsu #(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [AW-1:0]     i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [2:0]        i_MemOP,
    input  logic              i_wen,
    output logic              o_rvalid,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_err,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wmask,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [2:0]        memop_q, memop_d;
    logic              wen_q, wen_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [OW-1:0]     in_off;
    logic [OW-1:0]     in_amask;
    int                in_nb;
    logic              in_misalign;
    logic              in_bad_dw;
    logic              in_nop;
    logic [NB-1:0]     st_smask;
    logic [NB-1:0]     st_wmask;
    logic [XLEN-1:0]   st_wdata;

    int                ld_nb;
    int                ld_pad;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;

    // Request-side decode: size, alignment and the lane-shifted store image.
    always_comb begin
        in_off  = i_addr[OW-1:0];
        in_nb   = 1 << i_MemOP[2:1];
        if (in_nb > NB) begin
            in_nb = NB;
        end
        in_amask    = OW'(in_nb - 1);
        in_misalign = |(in_off & in_amask);
        in_bad_dw   = (i_MemOP == 3'b110) && (XLEN == 32);
        in_nop      = (i_MemOP == 3'b111);
        st_smask    = '0;
        for (int i = 0; i < NB; i++) begin
            st_smask[i] = (i < in_nb);
        end
        st_wmask = st_smask << in_off;
        st_wdata = i_wdata << {in_off, 3'b000};
    end

    // Move the addressed lane to the top, then shift back down so the arithmetic shift sign-extends.
    always_comb begin
        ld_nb = 1 << memop_q[2:1];
        if (ld_nb > NB) begin
            ld_nb = NB;
        end
        ld_pad   = XLEN - 8 * ld_nb;
        ld_shift = (i_mem_rdata >> {addr_q[OW-1:0], 3'b000}) << ld_pad;
        if (memop_q[0]) begin
            ld_ext = ld_shift >> ld_pad;
        end else begin
            ld_ext = $signed(ld_shift) >>> ld_pad;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        memop_d     = memop_q;
        wen_d       = wen_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    addr_d  = i_addr;
                    memop_d = i_MemOP;
                    wen_d   = i_wen;
                    if (in_nop || in_bad_dw || in_misalign) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        err_d    = !in_nop;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_wen;
                        mem_wdata_d = i_wen ? st_wdata : '0;
                        mem_wmask_d = i_wen ? st_wmask : '0;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    state_d     = S_WAIT;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (i_mem_rvalid) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = wen_q ? '0 : ld_ext;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= '0;
            memop_q     <= 3'b000;
            wen_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            memop_q     <= memop_d;
            wen_q       <= wen_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_rvalid    = rvalid_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = {addr_q[AW-1:OW], {OW{1'b0}}};
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wmask = mem_wmask_q;

endmodule
